// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one backing-memory port between icache line refills and dcache
// single-word accesses. Only one memory transaction is outstanding at a time.
// Response beats are routed back to whichever requester owns the transaction.
// If the icache is flushed while its refill is in flight, the refill still
// runs to completion on the memory side, but its beats are not delivered.
//
// Optional feature: define ARB_RR_EN to alternate the winner on a tie
// (round-robin against last_gnt). Without it, the dcache always wins a tie.
//
// Parameters
//   LINE_WORDS  beats per icache refill (power of 2, >= 1)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ic_req/ic_addr/ic_flush       icache refill request, line address, redirect
//   ic_gnt                        1-cycle pulse when the icache request is taken
//   ic_rvalid/rdata/rlast/error   refill beats returned to the icache
//   dc_req/we/addr/wdata/wmask    dcache single-word command
//   dc_gnt                        1-cycle pulse when the dcache request is taken
//   dc_rvalid/rdata/error         read data or write ack returned to the dcache
//   mem_req/we/addr/wdata/wmask   command to memory, held until mem_ready
//   mem_len                       beats-1 of the command
//   mem_ready                     memory accepted the command this cycle
//   mem_rvalid/rdata/error        response beats from memory
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ic_req,
    input  logic [29:0] ic_addr,
    input  logic        ic_flush,
    output logic        ic_gnt,
    output logic        ic_rvalid,
    output logic [31:0] ic_rdata,
    output logic        ic_rlast,
    output logic        ic_error,

    input  logic        dc_req,
    input  logic        dc_we,
    input  logic [29:0] dc_addr,
    input  logic [31:0] dc_wdata,
    input  logic [3:0]  dc_wmask,
    output logic        dc_gnt,
    output logic        dc_rvalid,
    output logic [31:0] dc_rdata,
    output logic        dc_error,

    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic [7:0]  mem_len,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);

    // Beat counter must hold LINE_WORDS itself, hence the extra bit.
    localparam int BW = $clog2(LINE_WORDS) + 1;

    localparam logic [29:0] LINE_MASK = ~30'(LINE_WORDS - 1);
    localparam logic [7:0]  IC_LEN    = 8'(LINE_WORDS - 1);
    localparam logic [BW-1:0] ONE_BEAT = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DC = 1'b0,
        OWN_IC = 1'b1
    } own_t;

    // Control state (reset)
    state_t        state;
    own_t          owner;
    own_t          last_gnt;
    logic          drop;
    logic [BW-1:0] beats_left;

    // Latched command (data path, not reset; outputs are gated by mem_req)
    logic          cmd_we;
    logic [29:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wmask;
    logic [7:0]    cmd_len;

    logic          ic_cand;
    logic          pick_ic;
    logic          pick_dc;
    logic          in_wait;
    logic          ic_kill;

    // A flush in IDLE withdraws the icache from this cycle's arbitration.
    assign ic_cand = ic_req & ~ic_flush;

    always_comb begin
        pick_ic = 1'b0;
        pick_dc = 1'b0;
        if (state == S_IDLE && !rst) begin
            if (ic_cand && dc_req) begin
`ifdef ARB_RR_EN
                if (last_gnt == OWN_DC) begin
                    pick_ic = 1'b1;
                end else begin
                    pick_dc = 1'b1;
                end
`else
                pick_dc = 1'b1;
`endif
            end else if (ic_cand) begin
                pick_ic = 1'b1;
            end else if (dc_req) begin
                pick_dc = 1'b1;
            end
        end
    end

`ifndef ARB_RR_EN
    // last_gnt is kept up to date in the fixed-priority build but not consulted.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_DC;
            last_gnt   <= OWN_DC;
            drop       <= 1'b0;
            beats_left <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_ic || pick_dc) begin
                        state    <= S_ISSUE;
                        owner    <= pick_ic ? OWN_IC : OWN_DC;
                        last_gnt <= pick_ic ? OWN_IC : OWN_DC;
                    end
                end
                S_ISSUE: begin
                    if (owner == OWN_IC && ic_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_ready) begin
                        state      <= S_WAIT;
                        beats_left <= BW'(cmd_len) + ONE_BEAT;
                    end
                end
                S_WAIT: begin
                    if (owner == OWN_IC && ic_flush) begin
                        drop <= 1'b1;
                    end
                    // Errors do not shorten the burst; every beat is counted.
                    if (mem_rvalid) begin
                        beats_left <= beats_left - ONE_BEAT;
                        if (beats_left == ONE_BEAT) begin
                            state <= S_IDLE;
                            drop  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Command capture on grant
    always_ff @(posedge clk) begin
        if (pick_ic) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= ic_addr & LINE_MASK;
            cmd_wdata <= '0;
            cmd_wmask <= '0;
            cmd_len   <= IC_LEN;
        end else if (pick_dc) begin
            cmd_we    <= dc_we;
            cmd_addr  <= dc_addr;
            cmd_wdata <= dc_wdata;
            cmd_wmask <= dc_wmask;
            cmd_len   <= 8'd0;
        end
    end

    assign ic_gnt = pick_ic;
    assign dc_gnt = pick_dc;

    // Memory command: data fields are forced to zero outside ISSUE so that the
    // port is quiet after reset without resetting the command registers.
    assign mem_req   = (state == S_ISSUE);
    assign mem_we    = mem_req & cmd_we;
    assign mem_addr  = mem_req ? cmd_addr  : '0;
    assign mem_wdata = mem_req ? cmd_wdata : '0;
    assign mem_wmask = mem_req ? cmd_wmask : '0;
    assign mem_len   = mem_req ? cmd_len   : '0;

    // Response routing. A flush arriving on the same cycle as a beat kills
    // that beat too, not just the ones after it.
    assign in_wait   = (state == S_WAIT);
    assign ic_kill   = drop | ic_flush;

    assign ic_rvalid = in_wait & mem_rvalid & (owner == OWN_IC) & ~ic_kill;
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign ic_error  = ic_rvalid & mem_error;
    assign ic_rlast  = ic_rvalid & (beats_left == ONE_BEAT);

    assign dc_rvalid = in_wait & mem_rvalid & (owner == OWN_DC);
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
    assign dc_error  = dc_rvalid & mem_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [29:0] ic_addr;
    logic        ic_flush;
    logic        ic_gnt;
    logic        ic_rvalid;
    logic [31:0] ic_rdata;
    logic        ic_rlast;
    logic        ic_error;
    logic        dc_req;
    logic        dc_we;
    logic [29:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_wmask;
    logic        dc_gnt;
    logic        dc_rvalid;
    logic [31:0] dc_rdata;
    logic        dc_error;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [7:0]  mem_len;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ic_v;
        logic        dc_v;
        logic        last;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];

    mem_port_arbiter #(.LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_flush(ic_flush),
        .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
        .ic_rlast(ic_rlast), .ic_error(ic_error),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .dc_error(dc_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_len(mem_len),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_error(mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the command presented in ISSUE, then accept it.
    task automatic accept(input string tag, input logic [29:0] a,
                          input logic we, input logic [7:0] len);
        #1;
        chk({tag, "_mem_req"},  mem_req,  1'b1);
        chk({tag, "_mem_addr"}, mem_addr, a);
        chk({tag, "_mem_we"},   mem_we,   we);
        chk({tag, "_mem_len"},  mem_len,  len);
        chk({tag, "_gnt_issue"}, {ic_gnt, dc_gnt}, 2'b00);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        chk({tag, "_mem_req_off"}, mem_req, 1'b0);
    endtask

    // Drive one response beat; the expected routing goes into the scoreboard
    // and is popped once the combinational outputs have settled.
    task automatic beat(input string tag, input logic [31:0] d, input logic e,
                        input logic flush, input logic x_ic, input logic x_dc,
                        input logic x_last);
        exp_t x;
        exp_t got;
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        mem_error  = e;
        ic_flush   = flush;
        x.ic_v = x_ic;
        x.dc_v = x_dc;
        x.last = x_last;
        x.err  = e;
        x.data = d;
        sbq.push_back(x);
        #1;
        got = sbq.pop_front();
        chk({tag, "_ic_rvalid"}, ic_rvalid, got.ic_v);
        chk({tag, "_ic_rdata"},  ic_rdata,  got.ic_v ? got.data : 32'h0);
        chk({tag, "_ic_rlast"},  ic_rlast,  got.last);
        chk({tag, "_ic_error"},  ic_error,  got.ic_v & got.err);
        chk({tag, "_dc_rvalid"}, dc_rvalid, got.dc_v);
        chk({tag, "_dc_rdata"},  dc_rdata,  got.dc_v ? got.data : 32'h0);
        chk({tag, "_dc_error"},  dc_error,  got.dc_v & got.err);
        chk({tag, "_gnt_wait"},  {ic_gnt, dc_gnt}, 2'b00);
        tick();
        mem_rvalid = 1'b0;
        mem_error  = 1'b0;
        ic_flush   = 1'b0;
    endtask

    logic exp_ic_win;
    logic mdl_last_ic;

    initial begin
        rst = 1'b1;
        ic_req = 0; ic_addr = '0; ic_flush = 0;
        dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0; dc_wmask = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; mem_error = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_gnt", {ic_gnt, dc_gnt}, 2'b00);
        chk("rst_mem_addr", mem_addr, 30'h0);
        chk("rst_rvalid", {ic_rvalid, dc_rvalid, ic_rlast}, 3'b000);

        // Icache refill, unaligned address gets line-aligned
        ic_req = 1; ic_addr = 30'h1003;
        #1;
        chk("t1_ic_gnt", ic_gnt, 1'b1);
        chk("t1_dc_gnt", dc_gnt, 1'b0);
        tick();
        ic_req = 0;
        accept("t1", 30'h1000, 1'b0, 8'd3);
        beat("t1_b1", 32'hA000_0001, 0, 0, 1, 0, 0);
        beat("t1_b2", 32'hA000_0002, 0, 0, 1, 0, 0);
        beat("t1_b3", 32'hA000_0003, 0, 0, 1, 0, 0);
        beat("t1_b4", 32'hA000_0004, 0, 0, 1, 0, 1);

        // Dcache write, with mem_ready withheld one cycle
        dc_req = 1; dc_we = 1; dc_addr = 30'h40; dc_wdata = 32'hDEADBEEF; dc_wmask = 4'hF;
        #1;
        chk("t2_dc_gnt", dc_gnt, 1'b1);
        tick();
        dc_req = 0;
        #1;
        chk("t2_hold_req", mem_req, 1'b1);
        chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t2_wmask", mem_wmask, 4'hF);
        tick();
        accept("t2", 30'h40, 1'b1, 8'd0);
        beat("t2_ack", 32'h0, 0, 0, 0, 1, 0);

        // Both requesters held continuously
        dc_we = 0; dc_addr = 30'h80; ic_addr = 30'h2000;
        ic_req = 1; dc_req = 1;
        mdl_last_ic = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            exp_ic_win = ~mdl_last_ic;
`else
            exp_ic_win = 1'b0;
`endif
            #1;
            chk($sformatf("t3_gnt%0d", i), {ic_gnt, dc_gnt}, {exp_ic_win, ~exp_ic_win});
            mdl_last_ic = exp_ic_win;
            tick();
            if (exp_ic_win) begin
                accept($sformatf("t3_i%0d", i), 30'h2000, 1'b0, 8'd3);
                for (int b = 0; b < 4; b++)
                    beat($sformatf("t3_i%0d_b%0d", i, b), 32'h3000 + b, 0, 0, 1, 0, b == 3);
            end else begin
                accept($sformatf("t3_d%0d", i), 30'h80, 1'b0, 8'd0);
                beat($sformatf("t3_d%0d_b", i), 32'h0D0D_0000 + i, 0, 0, 0, 1, 0);
            end
        end
        ic_req = 0; dc_req = 0;

        // Flush on beat 2 of a refill, with a dcache read waiting
        ic_req = 1; ic_addr = 30'h3004;
        #1;
        chk("t4_ic_gnt", ic_gnt, 1'b1);
        tick();
        ic_req = 0;
        dc_req = 1; dc_we = 0; dc_addr = 30'h123;
        accept("t4", 30'h3004, 1'b0, 8'd3);
        beat("t4_b1", 32'h4000_0001, 0, 0, 1, 0, 0);
        beat("t4_b2", 32'h4000_0002, 0, 1, 0, 0, 0);
        beat("t4_b3", 32'h4000_0003, 0, 0, 0, 0, 0);
        beat("t4_b4", 32'h4000_0004, 0, 0, 0, 0, 0);
        #1;
        chk("t4_dc_gnt_after", dc_gnt, 1'b1);
        tick();
        dc_req = 0;
        accept("t4_dc", 30'h123, 1'b0, 8'd0);
        beat("t4_dc_rd", 32'h5555_AAAA, 0, 0, 0, 1, 0);

        // Error on beat 1; the burst still runs to four beats
        ic_req = 1; ic_addr = 30'h0F08;
        #1;
        chk("t5_ic_gnt", ic_gnt, 1'b1);
        tick();
        ic_req = 0;
        accept("t5", 30'h0F08, 1'b0, 8'd3);
        beat("t5_b1", 32'h5000_0001, 1, 0, 1, 0, 0);
        beat("t5_b2", 32'h5000_0002, 0, 0, 1, 0, 0);
        beat("t5_b3", 32'h5000_0003, 0, 0, 1, 0, 0);
        beat("t5_b4", 32'h5000_0004, 0, 0, 1, 0, 1);

        // Flush in IDLE blocks the icache grant for that cycle
        ic_req = 1; ic_addr = 30'h0700; ic_flush = 1;
        #1;
        chk("t6_flush_idle_gnt", {ic_gnt, dc_gnt}, 2'b00);
        ic_flush = 0;
        #1;
        chk("t6_ic_gnt", ic_gnt, 1'b1);
        tick();
        ic_req = 0;
        accept("t6", 30'h0700, 1'b0, 8'd3);
        beat("t6_b1", 32'h6000_0001, 0, 0, 1, 0, 0);

        // Reset mid-burst
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("t6_rst_mem_req", mem_req, 1'b0);
        chk("t6_rst_gnt", {ic_gnt, dc_gnt}, 2'b00);
        mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("t6_stray_rvalid", {ic_rvalid, dc_rvalid, ic_rlast}, 3'b000);
        chk("t6_stray_rdata", ic_rdata, 32'h0);
        mem_rvalid = 0;
        ic_req = 1; ic_addr = 30'h2000;
        #1;
        chk("t6_regrant", ic_gnt, 1'b1);
        tick();
        ic_req = 0;
        accept("t6_new", 30'h2000, 1'b0, 8'd3);
        for (int b = 0; b < 4; b++)
            beat($sformatf("t6_new_b%0d", b), 32'h7000 + b, 0, 0, 1, 0, b == 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
